rst_sequencer: RTL and testbench
================================

// Module: rst_sequencer
// PURPOSE
//  Sequences bring-up and run control of the core under test. Sits between the bench clock/reset source
//  and the core. Holds all reset domains, then releases them staggered (memory -> regfile -> pipeline).
//  Gates core run, counts run cycles, and ends the run on halt or cycle-budget exhaustion.
// PARAMETERS
//  HOLD_CYCLES    5       cycles reset held after rst deasserts (>=1)
//  NUM_DOMAINS    3       reset domains; bit 0 released first (>=1)
//  STAGGER        2       cycles between consecutive domain releases (>=1)
//  TIMEOUT_CYCLES 100000  RUN-cycle budget before forced stop (>=2)
//  WDOG_CYCLES    1024    max consecutive RUN cycles without retire (watchdog only)
// PORTS
//  clk            in   1            system clock
//  rst            in   1            async, active-high reset
//  soft_rst_req   in   1            sync restart request, sampled every cycle
//  halt_i         in   1            core reached halt (ecall/ebreak), sampled in RUN only
//  retire_i       in   1            one instruction retired this cycle
//  dom_rst_o      out  NUM_DOMAINS  per-domain reset, active-high
//  core_run_o     out  1            core may fetch/issue
//  done_o         out  1            run ended (halt or timeout), sticky
//  timeout_o      out  1            run ended by budget/watchdog, sticky
//  cycle_cnt_o    out  32           RUN cycles elapsed, saturates at TIMEOUT_CYCLES
// BEHAVIOUR
//  - Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
//  - All outputs are registered. rst=1 forces immediately: state=HOLD, dom_rst_o=all 1s, core_run_o=0,
//    done_o=0, timeout_o=0, cycle_cnt_o=0, all internal counters=0.
//  - States: HOLD, RELEASE, RUN, HALTED, TIMED_OUT.
//  - HOLD: hold_cnt increments each edge. At hold_cnt==HOLD_CYCLES-1 -> RELEASE, with rel_cnt=0.
//  - RELEASE: rel_cnt increments each edge. dom_rst_o[i] clears on the edge where rel_cnt==i*STAGGER.
//    On the edge where the last domain clears, state -> RUN. core_run_o rises on the following edge.
//  - RUN: cycle_cnt increments each edge while core_run_o=1.
//    - halt_i=1 -> HALTED: done_o=1, core_run_o=0.
//    - cycle_cnt reaching TIMEOUT_CYCLES -> TIMED_OUT: done_o=1, timeout_o=1, core_run_o=0.
//    - halt_i and timeout in the same cycle: halt wins (timeout_o=0).
//  - HALTED and TIMED_OUT are terminal. dom_rst_o stays 0 so state can be inspected.
//    cycle_cnt_o is frozen. halt_i and retire_i are ignored.
//  - soft_rst_req=1 in any state has priority over halt and timeout. Next edge: state=HOLD and all
//    outputs/counters return to reset values. Sequence restarts as if rst had deasserted.
//  - rst asserted mid-RELEASE or mid-RUN: immediate full reset, no partial release is remembered.
//  - halt_i or retire_i in HOLD or RELEASE: ignored.
//  - cycle_cnt arithmetic is 32-bit unsigned. TIMEOUT_CYCLES < 2^32 prevents wrap.
// CONFIGURATION
//  RST_SEQ_WDOG_EN defined:
//    - idle counter clears on retire_i and increments each RUN cycle without retire.
//    - reaching WDOG_CYCLES -> TIMED_OUT (timeout_o=1), same priority as the budget timeout.
//    - idle counter clears on soft_rst_req/rst.
//  RST_SEQ_WDOG_EN undefined: no watchdog logic; retire_i unused; only the budget ends a stuck run.
// STRUCTURE
//  - rst_seq_pkg: state enum typedef rst_seq_state_e, CYC_W=32 constant.
//  - rst_seq_wdog sub-module: idle counter plus expiry flag. Instantiated only under RST_SEQ_WDOG_EN.
//  - FSM and release/cycle counters live in rst_sequencer.
// TESTING (defaults; edge 1 = first posedge with rst=0)
//  1 Release: after edge 6 dom_rst_o=3'b110; after edge 8 3'b100; after edge 10 3'b000;
//    after edge 11 core_run_o=1.
//  2 Halt: pulse halt_i at RUN cycle_cnt=40 -> next edge done_o=1, timeout_o=0, core_run_o=0,
//    cycle_cnt_o frozen at 41.
//  3 Budget: TIMEOUT_CYCLES=20, no halt -> cycle_cnt_o=20, done_o=1, timeout_o=1.
//    Assert halt_i on the same edge instead -> timeout_o=0.
//  4 Soft restart: soft_rst_req in HALTED -> next edge dom_rst_o=3'b111, done_o=0, cycle_cnt_o=0;
//    release timing of test 1 repeats.
//  5 Async reset mid-RELEASE (dom_rst_o=3'b100): raise rst between edges ->
//    dom_rst_o=3'b111 immediately, before the next edge.
//  6 RST_SEQ_WDOG_EN, WDOG_CYCLES=8: retire_i every cycle for 10 cycles, then 0 ->
//    timeout_o=1 exactly 8 RUN cycles later; without the macro, no timeout.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the reset sequencer.
package rst_seq_pkg;

    localparam int CYC_W = 32;

    typedef enum logic [2:0] {
        ST_HOLD      = 3'd0,
        ST_RELEASE   = 3'd1,
        ST_RUN       = 3'd2,
        ST_HALTED    = 3'd3,
        ST_TIMED_OUT = 3'd4
    } rst_seq_state_e;

endpackage

// File: rtl/rst_sequencer_if.sv
// Control/status bundle between the bench side (master) and the reset sequencer (slave).
interface rst_sequencer_if #(
    parameter int NUM_DOMAINS = 3
);
    logic                           soft_rst_req;
    logic                           halt_i;
    logic                           retire_i;
    logic [NUM_DOMAINS-1:0]         dom_rst_o;
    logic                           core_run_o;
    logic                           done_o;
    logic                           timeout_o;
    logic [rst_seq_pkg::CYC_W-1:0]  cycle_cnt_o;

    modport master (
        output soft_rst_req, halt_i, retire_i,
        input  dom_rst_o, core_run_o, done_o, timeout_o, cycle_cnt_o
    );

    modport slave (
        input  soft_rst_req, halt_i, retire_i,
        output dom_rst_o, core_run_o, done_o, timeout_o, cycle_cnt_o
    );
endinterface

// File: rtl/rst_seq_wdog.sv
// Retire watchdog: counts consecutive running cycles without a retire and flags
// the cycle on which the idle run reaches WDOG_CYCLES. Used only with RST_SEQ_WDOG_EN.
module rst_seq_wdog
    import rst_seq_pkg::*;
#(
    parameter int WDOG_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_run,
    input  logic i_retire,
    output logic o_expire
);
    localparam logic [CYC_W-1:0] IDLE_LAST = CYC_W'(WDOG_CYCLES - 1);

    logic [CYC_W-1:0] r_idle_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle_cnt <= '0;
        end else if (i_clr || !i_run || i_retire) begin
            r_idle_cnt <= '0;
        end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
        end
    end

    // Asserted on the edge that would make the idle count reach WDOG_CYCLES.
    assign o_expire = i_run && !i_retire && (r_idle_cnt == IDLE_LAST);

endmodule

// File: rtl/rst_sequencer.sv
// Bring-up sequencer: holds reset domains, releases them staggered, gates and times the core run.
// Optional retire watchdog is built when RST_SEQ_WDOG_EN is defined.
//
// state        | meaning
// ST_HOLD      | all domains in reset, counting HOLD_CYCLES
// ST_RELEASE   | domains released one by one every STAGGER cycles
// ST_RUN       | core enabled, run cycles counted
// ST_HALTED    | core halted itself, terminal
// ST_TIMED_OUT | budget or watchdog expired, terminal
module rst_sequencer
    import rst_seq_pkg::*;
#(
    parameter int HOLD_CYCLES    = 5,
    parameter int NUM_DOMAINS    = 3,
    parameter int STAGGER        = 2,
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int WDOG_CYCLES    = 1024
) (
    input  logic              clk,
    input  logic              rst,
    rst_sequencer_if.slave    bus
);
    localparam logic [CYC_W-1:0] HOLD_LAST   = CYC_W'(HOLD_CYCLES - 1);
    localparam logic [CYC_W-1:0] REL_LAST    = CYC_W'((NUM_DOMAINS - 1) * STAGGER);
    localparam logic [CYC_W-1:0] TIMEOUT_VAL = CYC_W'(TIMEOUT_CYCLES);

    rst_seq_state_e         r_state;
    logic [CYC_W-1:0]       r_hold_cnt;
    logic [CYC_W-1:0]       r_rel_cnt;
    logic [CYC_W-1:0]       r_cycle_cnt;
    logic [NUM_DOMAINS-1:0] r_dom_rst;
    logic                   r_core_run;
    logic                   r_done;
    logic                   r_timeout;

    logic [CYC_W-1:0]       w_cycle_next;
    logic                   w_running;
    logic                   w_wdog_hit;

    assign w_cycle_next = r_cycle_cnt + 1'b1;
    assign w_running    = (r_state == ST_RUN) && r_core_run;

`ifdef RST_SEQ_WDOG_EN
    rst_seq_wdog #(
        .WDOG_CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk      (clk),
        .rst      (rst),
        .i_clr    (bus.soft_rst_req),
        .i_run    (w_running),
        .i_retire (bus.retire_i),
        .o_expire (w_wdog_hit)
    );
`else
    logic w_unused_wdog;
    assign w_unused_wdog = bus.retire_i & (WDOG_CYCLES > 0);
    assign w_wdog_hit    = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_rel_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_dom_rst   <= '1;
            r_core_run  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else if (bus.soft_rst_req) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_rel_cnt   <= '0;
            r_cycle_cnt <= '0;
            r_dom_rst   <= '1;
            r_core_run  <= 1'b0;
            r_done      <= 1'b0;
            r_timeout   <= 1'b0;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state    <= ST_RELEASE;
                        r_hold_cnt <= '0;
                        r_rel_cnt  <= '0;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                ST_RELEASE: begin
                    r_rel_cnt <= r_rel_cnt + 1'b1;
                    for (int i = 0; i < NUM_DOMAINS; i++) begin
                        if (r_rel_cnt == CYC_W'(i * STAGGER)) begin
                            r_dom_rst[i] <= 1'b0;
                        end
                    end
                    if (r_rel_cnt == REL_LAST) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!r_core_run) begin
                        if (bus.halt_i) begin
                            r_state <= ST_HALTED;
                            r_done  <= 1'b1;
                        end else begin
                            r_core_run <= 1'b1;
                        end
                    end else begin
                        // The cycle in which halt/timeout is seen is still a counted run cycle.
                        r_cycle_cnt <= w_cycle_next;
                        if (bus.halt_i) begin
                            r_state    <= ST_HALTED;
                            r_done     <= 1'b1;
                            r_core_run <= 1'b0;
                        end else if ((w_cycle_next == TIMEOUT_VAL) || w_wdog_hit) begin
                            r_state    <= ST_TIMED_OUT;
                            r_done     <= 1'b1;
                            r_timeout  <= 1'b1;
                            r_core_run <= 1'b0;
                        end
                    end
                end
                ST_HALTED, ST_TIMED_OUT: begin
                    r_state <= r_state;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign bus.dom_rst_o   = r_dom_rst;
    assign bus.core_run_o  = r_core_run;
    assign bus.done_o      = r_done;
    assign bus.timeout_o   = r_timeout;
    assign bus.cycle_cnt_o = r_cycle_cnt;

endmodule

// File: tb/tb_rst_sequencer.sv
// Directed bench: dut_a uses the default budget, dut_b a budget of 20; both use a watchdog of 8.
module tb_rst_sequencer;
    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    rst_sequencer_if #(.NUM_DOMAINS(3)) if_a ();
    rst_sequencer_if #(.NUM_DOMAINS(3)) if_b ();

    rst_sequencer #(
        .HOLD_CYCLES(5), .NUM_DOMAINS(3), .STAGGER(2), .TIMEOUT_CYCLES(100000), .WDOG_CYCLES(8)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (if_a.slave)
    );

    rst_sequencer #(
        .HOLD_CYCLES(5), .NUM_DOMAINS(3), .STAGGER(2), .TIMEOUT_CYCLES(20), .WDOG_CYCLES(8)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_release(input string pfx);
        step(6);
        chk({pfx, " dom e6 a"}, 32'(if_a.dom_rst_o), 32'b110);
        chk({pfx, " dom e6 b"}, 32'(if_b.dom_rst_o), 32'b110);
        step(2);
        chk({pfx, " dom e8 a"}, 32'(if_a.dom_rst_o), 32'b100);
        step(2);
        chk({pfx, " dom e10 a"}, 32'(if_a.dom_rst_o), 32'b000);
        chk({pfx, " run e10 a"}, 32'(if_a.core_run_o), 32'd0);
        step(1);
        chk({pfx, " run e11 a"}, 32'(if_a.core_run_o), 32'd1);
        chk({pfx, " run e11 b"}, 32'(if_b.core_run_o), 32'd1);
        chk({pfx, " cnt e11 a"}, if_a.cycle_cnt_o, 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst = 1'b1;
        if_a.soft_rst_req = 1'b0; if_a.halt_i = 1'b0; if_a.retire_i = 1'b1;
        if_b.soft_rst_req = 1'b0; if_b.halt_i = 1'b0; if_b.retire_i = 1'b1;

        #12;
        chk("rst dom",     32'(if_a.dom_rst_o),  32'b111);
        chk("rst run",     32'(if_a.core_run_o), 32'd0);
        chk("rst done",    32'(if_a.done_o),     32'd0);
        chk("rst timeout", 32'(if_a.timeout_o),  32'd0);
        chk("rst cnt",     if_a.cycle_cnt_o,     32'd0);

        @(negedge clk);
        rst = 1'b0;
        step(5);
        chk("dom e5 a", 32'(if_a.dom_rst_o), 32'b111);
        step(1);
        chk("dom e6 a", 32'(if_a.dom_rst_o), 32'b110);
        step(2);
        chk("dom e8 a", 32'(if_a.dom_rst_o), 32'b100);
        step(2);
        chk("dom e10 a", 32'(if_a.dom_rst_o), 32'b000);
        chk("run e10 a", 32'(if_a.core_run_o), 32'd0);
        step(1);
        chk("run e11 a", 32'(if_a.core_run_o), 32'd1);

        // budget timeout on dut_b at edge 31
        step(19);
        chk("budget cnt e30 b",  if_b.cycle_cnt_o,      32'd19);
        chk("budget done e30 b", 32'(if_b.done_o),      32'd0);
        step(1);
        chk("budget cnt b",     if_b.cycle_cnt_o,      32'd20);
        chk("budget done b",    32'(if_b.done_o),      32'd1);
        chk("budget timeout b", 32'(if_b.timeout_o),   32'd1);
        chk("budget run b",     32'(if_b.core_run_o),  32'd0);
        chk("cnt e31 a",        if_a.cycle_cnt_o,      32'd20);

        // halt on dut_a at cycle_cnt 40
        step(20);
        chk("cnt e51 a", if_a.cycle_cnt_o, 32'd40);
        if_a.halt_i = 1'b1;
        step(1);
        if_a.halt_i = 1'b0;
        chk("halt done a",    32'(if_a.done_o),     32'd1);
        chk("halt timeout a", 32'(if_a.timeout_o),  32'd0);
        chk("halt run a",     32'(if_a.core_run_o), 32'd0);
        chk("halt cnt a",     if_a.cycle_cnt_o,     32'd41);
        if_a.retire_i = 1'b0;
        step(12);
        chk("halt frozen cnt a", if_a.cycle_cnt_o,    32'd41);
        chk("halt sticky a",     32'(if_a.done_o),    32'd1);
        chk("halted timeout a",  32'(if_a.timeout_o), 32'd0);
        chk("b frozen cnt",      if_b.cycle_cnt_o,    32'd20);
        if_a.retire_i = 1'b1;

        // soft restart out of HALTED / TIMED_OUT
        if_a.soft_rst_req = 1'b1;
        if_b.soft_rst_req = 1'b1;
        step(1);
        if_a.soft_rst_req = 1'b0;
        if_b.soft_rst_req = 1'b0;
        chk("soft dom a",     32'(if_a.dom_rst_o), 32'b111);
        chk("soft done a",    32'(if_a.done_o),    32'd0);
        chk("soft cnt a",     if_a.cycle_cnt_o,    32'd0);
        chk("soft timeout b", 32'(if_b.timeout_o), 32'd0);
        chk_release("soft");

        // halt coincident with budget expiry on dut_b
        step(19);
        chk("tie cnt e30 b", if_b.cycle_cnt_o, 32'd19);
        if_b.halt_i = 1'b1;
        step(1);
        if_b.halt_i = 1'b0;
        chk("tie cnt b",     if_b.cycle_cnt_o,     32'd20);
        chk("tie done b",    32'(if_b.done_o),     32'd1);
        chk("tie timeout b", 32'(if_b.timeout_o),  32'd0);

        // watchdog on dut_a: retiring through edge 41, idle from edge 42
        step(10);
        if_a.retire_i = 1'b0;
        step(7);
        chk("wdog e48 timeout a", 32'(if_a.timeout_o), 32'd0);
        step(1);
`ifdef RST_SEQ_WDOG_EN
        chk("wdog timeout a", 32'(if_a.timeout_o),  32'd1);
        chk("wdog done a",    32'(if_a.done_o),     32'd1);
        chk("wdog run a",     32'(if_a.core_run_o), 32'd0);
        chk("wdog cnt a",     if_a.cycle_cnt_o,     32'd38);
`else
        chk("no wdog timeout a", 32'(if_a.timeout_o),  32'd0);
        chk("no wdog run a",     32'(if_a.core_run_o), 32'd1);
        chk("no wdog cnt a",     if_a.cycle_cnt_o,     32'd38);
`endif
        if_a.retire_i = 1'b1;

        // async reset in the middle of RELEASE
        if_a.soft_rst_req = 1'b1;
        if_b.soft_rst_req = 1'b1;
        step(1);
        if_a.soft_rst_req = 1'b0;
        if_b.soft_rst_req = 1'b0;
        step(8);
        chk("mid rel dom a", 32'(if_a.dom_rst_o), 32'b100);
        #2;
        rst = 1'b1;
        #1;
        chk("async dom a", 32'(if_a.dom_rst_o), 32'b111);
        chk("async dom b", 32'(if_b.dom_rst_o), 32'b111);
        @(negedge clk);
        rst = 1'b0;
        chk_release("post rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
